// File: rtl/debug_frame_sequencer.sv
// ---------------------------------------------------------------------------
// debug_frame_sequencer
//
// Replays a host-loaded script of debug control commands onto the pipeline's
// 32-bit frame port. Each command frame is held for (hold+1) cycles and is
// followed by GAP_CYCLES idle cycles. The returning frame is captured once
// per command into a first-word fall-through response FIFO.
//
// Ports:
//   i_clock, i_reset     clock, asynchronous active-high reset
//   i_cmd_wr/i_cmd_data  append a script entry {code,addr_type,address,hold}
//   i_clear              empty the script (IDLE only, wins over i_cmd_wr)
//   i_start/i_loop       begin replay; loop mode is sampled at start
//   i_abort              stop replay at once (ISSUE/GAP only)
//   o_frame_to_mips      registered frame {code,valid,addr_type,address}
//   i_frame_from_mips    frame returned by the pipeline
//   i_rsp_rd             pop the response FIFO
//   o_rsp_data           FIFO head, valid while !o_rsp_empty
//   o_rsp_empty          response FIFO empty
//   o_cmd_full           script memory full
//   o_busy               replay in progress
//   o_done               one-cycle pulse when a non-looping script ends
//   o_overflow           sticky, a response was dropped on a full FIFO
// ---------------------------------------------------------------------------
module debug_frame_sequencer #(
  parameter int NB_CODE      = 6,
  parameter int NB_ADDR_TYPE = 9,
  parameter int NB_ADDR      = 16,
  parameter int NB_FRAME     = 32,
  parameter int NB_HOLD      = 4,
  parameter int SCRIPT_DEPTH = 16,
  parameter int RESP_DEPTH   = 8,
  parameter int GAP_CYCLES   = 2,
  parameter logic [NB_CODE-1:0] IDLE_CODE = 6'b001010
) (
  input  logic                                         i_clock,
  input  logic                                         i_reset,
  input  logic                                         i_cmd_wr,
  input  logic [NB_CODE+NB_ADDR_TYPE+NB_ADDR+NB_HOLD-1:0] i_cmd_data,
  input  logic                                         i_clear,
  input  logic                                         i_start,
  input  logic                                         i_loop,
  input  logic                                         i_abort,
  output logic [NB_FRAME-1:0]                          o_frame_to_mips,
  input  logic [NB_FRAME-1:0]                          i_frame_from_mips,
  input  logic                                         i_rsp_rd,
  output logic [NB_FRAME-1:0]                          o_rsp_data,
  output logic                                         o_rsp_empty,
  output logic                                         o_cmd_full,
  output logic                                         o_busy,
  output logic                                         o_done,
  output logic                                         o_overflow
);

  localparam int NB_CMD = NB_CODE + NB_ADDR_TYPE + NB_ADDR + NB_HOLD;
  localparam int IDX_W  = $clog2(SCRIPT_DEPTH);
  localparam int RSP_AW = $clog2(RESP_DEPTH);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
  localparam int CNT_W  = (NB_HOLD > GAP_W) ? NB_HOLD : GAP_W;
  localparam logic [NB_FRAME-1:0] IDLE_FRAME = {IDLE_CODE, {(NB_FRAME-NB_CODE){1'b0}}};

  typedef enum logic [1:0] {IDLE, ISSUE, GAP, DONE} state_t;

  state_t state, state_next;

  logic [NB_CMD-1:0]   script_mem [SCRIPT_DEPTH];
  logic [NB_FRAME-1:0] rsp_mem    [RESP_DEPTH];

  logic [IDX_W:0]      count;
  logic [IDX_W-1:0]    idx;
  logic                loop_mode;
  logic [CNT_W-1:0]    cnt;
  logic [NB_FRAME-1:0] frame_q, frame_next;
  logic                overflow;
  logic [RSP_AW:0]     wr_ptr, rd_ptr;

  logic [NB_CMD-1:0]       cur_cmd;
  logic [NB_CODE-1:0]      cur_code;
  logic [NB_ADDR_TYPE-1:0] cur_at;
  logic [NB_ADDR-1:0]      cur_addr;
  logic [NB_HOLD-1:0]      cur_hold;

  logic start_ok, hold_done, gap_done, more_cmds;
  logic script_wr, clear_ok;
  logic rsp_full, rsp_empty, capture, rsp_pop, rsp_push, rsp_drop;

  // Fields of the script entry currently being replayed
  assign cur_cmd  = script_mem[idx];
  assign cur_code = cur_cmd[NB_CMD-1 -: NB_CODE];
  assign cur_at   = cur_cmd[NB_ADDR+NB_HOLD +: NB_ADDR_TYPE];
  assign cur_addr = cur_cmd[NB_HOLD +: NB_ADDR];
  assign cur_hold = cur_cmd[NB_HOLD-1:0];

  // cnt restarts at zero on every state change, so it counts cycles spent
  // in the current ISSUE or GAP phase.
  assign hold_done = (cnt == CNT_W'(cur_hold));
  assign gap_done  = (cnt == CNT_W'(GAP_CYCLES - 1));
  assign more_cmds = (({1'b0, idx} + (IDX_W+1)'(1)) < count);
  assign start_ok  = (state == IDLE) && i_start && (count != '0);

  assign o_cmd_full = (count == (IDX_W+1)'(SCRIPT_DEPTH));
  assign clear_ok   = (state == IDLE) && i_clear;
  assign script_wr  = (state == IDLE) && i_cmd_wr && !i_clear && !o_cmd_full;

  // Extra pointer bit distinguishes full from empty when the indices match
  assign rsp_empty = (wr_ptr == rd_ptr);
  assign rsp_full  = (wr_ptr[RSP_AW] != rd_ptr[RSP_AW]) &&
                     (wr_ptr[RSP_AW-1:0] == rd_ptr[RSP_AW-1:0]);
  assign capture   = (state == GAP) && (cnt == '0) && !i_abort;
  assign rsp_pop   = i_rsp_rd && !rsp_empty;
  assign rsp_push  = capture && (!rsp_full || rsp_pop);
  assign rsp_drop  = capture && rsp_full && !rsp_pop;

  assign o_rsp_empty     = rsp_empty;
  assign o_rsp_data      = rsp_mem[rd_ptr[RSP_AW-1:0]];
  assign o_frame_to_mips = frame_q;
  assign o_overflow      = overflow;

  // State register
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; abort wins over every other exit from ISSUE/GAP
  always_comb begin
    state_next = state;
    case (state)
      IDLE:  if (start_ok) state_next = ISSUE;
      ISSUE: begin
        if (i_abort)        state_next = IDLE;
        else if (hold_done) state_next = GAP;
      end
      GAP: begin
        if (i_abort)       state_next = IDLE;
        else if (gap_done) state_next = (more_cmds || loop_mode) ? ISSUE : DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs; the frame is computed here and registered, so a command frame
  // shows up one cycle after ISSUE is entered and lingers one cycle into GAP.
  always_comb begin
    o_busy     = (state == ISSUE) || (state == GAP);
    o_done     = (state == DONE);
    frame_next = IDLE_FRAME;
    if (state == ISSUE && !i_abort) frame_next = {cur_code, 1'b1, cur_at, cur_addr};
  end

  // Replay bookkeeping, script count, response pointers and sticky overflow
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      count     <= '0;
      idx       <= '0;
      loop_mode <= 1'b0;
      cnt       <= '0;
      frame_q   <= IDLE_FRAME;
      overflow  <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else begin
      frame_q <= frame_next;
      cnt     <= (state_next != state) ? '0 : cnt + CNT_W'(1);

      if (clear_ok)       count <= '0;
      else if (script_wr) count <= count + (IDX_W+1)'(1);

      if (start_ok) begin
        loop_mode <= i_loop;
        idx       <= '0;
      end else if (state == GAP && state_next == ISSUE) begin
        idx <= more_cmds ? idx + IDX_W'(1) : '0;
      end

      if (start_ok)      overflow <= 1'b0;
      else if (rsp_drop) overflow <= 1'b1;

      if (rsp_push) wr_ptr <= wr_ptr + (RSP_AW+1)'(1);
      if (rsp_pop)  rd_ptr <= rd_ptr + (RSP_AW+1)'(1);
    end
  end

  // Storage arrays carry no reset; the count and pointers define what is valid
  always_ff @(posedge i_clock) begin
    if (script_wr) script_mem[count[IDX_W-1:0]] <= i_cmd_data;
    if (rsp_push)  rsp_mem[wr_ptr[RSP_AW-1:0]]  <= i_frame_from_mips;
  end

endmodule

// File: tb/tb_debug_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_debug_frame_sequencer
//
// Drives debug_frame_sequencer with directed and randomized scripts. The
// reference model describes a replay as a timeline: each command contributes
// one entry cycle, hold+1 cycles of its valid frame (the response is taken
// on the last of these), then GAP-1 further idle cycles. Responses go into a
// bounded queue standing in for the FIFO.
// ---------------------------------------------------------------------------
module tb_debug_frame_sequencer;

  localparam int GAP = 2;
  localparam int RSP_DEPTH = 8;
  localparam int SCRIPT_DEPTH = 16;
  localparam logic [31:0] IDLE_FRAME = 32'h2800_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        cmd_wr = 1'b0;
  logic [34:0] cmd_data = '0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        loop = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] frame_to_mips;
  logic [31:0] frame_from_mips = '0;
  logic        rsp_rd = 1'b0;
  logic [31:0] rsp_data;
  logic        rsp_empty, cmd_full, busy, done, overflow;

  int checks = 0;
  int fails  = 0;

  // Model state
  logic [5:0]  m_code [SCRIPT_DEPTH];
  logic [8:0]  m_at   [SCRIPT_DEPTH];
  logic [15:0] m_addr [SCRIPT_DEPTH];
  logic [3:0]  m_hold [SCRIPT_DEPTH];
  int          m_count = 0;
  logic [31:0] rsp_q[$];
  logic        m_overflow = 1'b0;

  typedef struct packed {
    logic [31:0] frame;
    logic        busy;
    logic        done;
    logic        cap;
    logic        abrt;
  } step_t;
  step_t tl[$];

  debug_frame_sequencer dut (
    .i_clock(clock), .i_reset(reset), .i_cmd_wr(cmd_wr), .i_cmd_data(cmd_data),
    .i_clear(clear), .i_start(start), .i_loop(loop), .i_abort(abort),
    .o_frame_to_mips(frame_to_mips), .i_frame_from_mips(frame_from_mips),
    .i_rsp_rd(rsp_rd), .o_rsp_data(rsp_data), .o_rsp_empty(rsp_empty),
    .o_cmd_full(cmd_full), .o_busy(busy), .o_done(done), .o_overflow(overflow)
  );

  // Free-running clock, period 10
  always #5 clock = ~clock;

  // Single comparison point for the whole bench
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  function automatic logic [31:0] entryFrame(input int j);
    return {m_code[j], 1'b1, m_at[j], m_addr[j]};
  endfunction

  task automatic checkIdleOutputs(input string tag);
    checkOutput({tag, " frame"},    frame_to_mips, IDLE_FRAME);
    checkOutput({tag, " busy"},     32'(busy), 32'd0);
    checkOutput({tag, " done"},     32'(done), 32'd0);
    checkOutput({tag, " overflow"}, 32'(overflow), 32'd0);
    checkOutput({tag, " empty"},    32'(rsp_empty), 32'd1);
    checkOutput({tag, " full"},     32'(cmd_full), 32'd0);
  endtask

  task automatic loadEntry(input logic [5:0] code, input logic [8:0] at,
                           input logic [15:0] addr, input logic [3:0] hold);
    @(negedge clock);
    cmd_wr   = 1'b1;
    cmd_data = {code, at, addr, hold};
    @(negedge clock);
    cmd_wr = 1'b0;
    if (m_count < SCRIPT_DEPTH) begin
      m_code[m_count] = code;
      m_at[m_count]   = at;
      m_addr[m_count] = addr;
      m_hold[m_count] = hold;
      m_count++;
    end
  endtask

  task automatic loadRandom(input int n, input int max_hold);
    for (int j = 0; j < n; j++)
      loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'($urandom_range(max_hold, 0)));
  endtask

  task automatic clearScript();
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    m_count = 0;
  endtask

  // Expected per-cycle behaviour after the start edge
  task automatic buildTimeline(input bit loop_on, input int passes);
    tl.delete();
    for (int p = 0; p < passes; p++)
      for (int j = 0; j < m_count; j++) begin
        tl.push_back('{IDLE_FRAME, 1'b1, 1'b0, 1'b0, 1'b0});
        for (int c = 0; c <= int'(m_hold[j]); c++)
          tl.push_back('{entryFrame(j), 1'b1, 1'b0, (c == int'(m_hold[j])), 1'b0});
        for (int g = 1; g < GAP; g++)
          tl.push_back('{IDLE_FRAME, 1'b1, 1'b0, 1'b0, 1'b0});
      end
    if (loop_on) begin
      // Next pass begins; abort on the first cycle its frame is on the bus
      tl.push_back('{IDLE_FRAME, 1'b1, 1'b0, 1'b0, 1'b0});
      tl.push_back('{entryFrame(0), 1'b1, 1'b0, 1'b0, 1'b1});
      tl.push_back('{IDLE_FRAME, 1'b0, 1'b0, 1'b0, 1'b0});
      tl.push_back('{IDLE_FRAME, 1'b0, 1'b0, 1'b0, 1'b0});
    end else begin
      tl.push_back('{IDLE_FRAME, 1'b0, 1'b1, 1'b0, 1'b0});
      tl.push_back('{IDLE_FRAME, 1'b0, 1'b0, 1'b0, 1'b0});
    end
  endtask

  // Start a replay and check every cycle of it against the timeline
  task automatic applyStimulus(input bit loop_on, input int passes, input bit pop_on_cap);
    logic [31:0] v;
    buildTimeline(loop_on, passes);
    @(negedge clock);
    start = 1'b1;
    loop  = loop_on;
    @(posedge clock);
    m_overflow = 1'b0;
    for (int k = 0; k < tl.size(); k++) begin
      @(negedge clock);
      start = 1'b0;
      loop  = 1'b0;
      checkOutput($sformatf("frame@%0d", k + 1), frame_to_mips, tl[k].frame);
      checkOutput($sformatf("busy@%0d", k + 1), 32'(busy), 32'(tl[k].busy));
      checkOutput($sformatf("done@%0d", k + 1), 32'(done), 32'(tl[k].done));
      checkOutput($sformatf("empty@%0d", k + 1), 32'(rsp_empty), 32'(rsp_q.size() == 0));
      checkOutput($sformatf("overflow@%0d", k + 1), 32'(overflow), 32'(m_overflow));
      if (rsp_q.size() > 0)
        checkOutput($sformatf("head@%0d", k + 1), rsp_data, rsp_q[0]);
      v = $urandom;
      frame_from_mips = v;
      abort  = tl[k].abrt;
      rsp_rd = pop_on_cap && tl[k].cap;
      if (tl[k].cap) begin
        if (pop_on_cap && rsp_q.size() > 0) void'(rsp_q.pop_front());
        if (rsp_q.size() < RSP_DEPTH) rsp_q.push_back(v);
        else                          m_overflow = 1'b1;
      end
    end
    abort  = 1'b0;
    rsp_rd = 1'b0;
  endtask

  task automatic drainResponses();
    while (rsp_q.size() > 0) begin
      @(negedge clock);
      rsp_rd = 1'b0;
      checkOutput("drain empty", 32'(rsp_empty), 32'd0);
      checkOutput("drain data", rsp_data, rsp_q[0]);
      rsp_rd = 1'b1;
      void'(rsp_q.pop_front());
    end
    @(negedge clock);
    rsp_rd = 1'b0;
    checkOutput("drained empty", 32'(rsp_empty), 32'd1);
  endtask

  initial begin
    // Reset window from t=20 to t=140
    #20 reset = 1'b1;
    #80 checkIdleOutputs("reset");
    #40 reset = 1'b0;
    $display("[TB] reset released");

    // Directed three-command script
    loadEntry(6'b000010, 9'h000, 16'h0000, 4'd1);
    loadEntry(6'b001010, 9'h002, 16'h0000, 4'd1);
    loadEntry(6'b000001, 9'h000, 16'h0000, 4'd1);
    checkOutput("frame mode_set_step", entryFrame(1), 32'h2A02_0000);
    applyStimulus(1'b0, 1, 1'b0);
    checkOutput("three responses", 32'(rsp_q.size()), 32'd3);
    drainResponses();

    // Randomized scripts, alternating pop-on-capture
    for (int r = 0; r < 6; r++) begin
      clearScript();
      loadRandom($urandom_range(5, 1), 3);
      applyStimulus(1'b0, 1, r[0]);
      drainResponses();
    end

    // Full script, 17th write ignored, long hold on entry 0
    clearScript();
    loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'd15);
    loadRandom(15, 2);
    checkOutput("cmd_full at 16", 32'(cmd_full), 32'd1);
    loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'd3);
    checkOutput("cmd_full after 17th", 32'(cmd_full), 32'd1);
    applyStimulus(1'b0, 1, 1'b0);
    checkOutput("overflow after 16", 32'(overflow), 32'd1);
    drainResponses();

    // Loop mode, nine passes without pops, then abort mid-ISSUE
    clearScript();
    loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'd2);
    applyStimulus(1'b1, 9, 1'b0);
    checkOutput("loop fifo count", 32'(rsp_q.size()), 32'd8);
    checkOutput("loop overflow", 32'(overflow), 32'd1);

    // Full FIFO, pop on the capture cycle: stays full, no overflow
    applyStimulus(1'b0, 1, 1'b1);
    checkOutput("pop-on-capture count", 32'(rsp_q.size()), 32'd8);
    checkOutput("pop-on-capture overflow", 32'(overflow), 32'd0);
    drainResponses();

    // Clear together with a write leaves an empty script; start is ignored
    @(negedge clock);
    clear    = 1'b1;
    cmd_wr   = 1'b1;
    cmd_data = 35'($urandom);
    @(negedge clock);
    clear  = 1'b0;
    cmd_wr = 1'b0;
    m_count = 0;
    start  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("start on empty busy", 32'(busy), 32'd0);
    @(negedge clock);
    checkOutput("start on empty frame", frame_to_mips, IDLE_FRAME);

    // Asynchronous reset in the first GAP cycle
    loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'd1);
    loadEntry(6'($urandom), 9'($urandom), 16'($urandom), 4'd1);
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("pre-reset frame", frame_to_mips, entryFrame(0));
    #2 reset = 1'b1;
    #1 checkIdleOutputs("async reset");
    @(negedge clock);
    reset = 1'b0;
    m_count = 0;
    rsp_q.delete();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("script lost busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
